fpu_seq_muldiv: RTL

Parametrised sequential mantissa arithmetic engine for the FPU datapath. It replaces the fixed-width multiply and divide sequencers with one unit that has a WIDTH parameter and an op select. It performs an unsigned shift-add multiply or an unsigned restoring divide on WIDTH-bit operands. It adds divide-by-zero detection and a done/ack handshake.

---
 rtl/fpu_seq_muldiv_if.sv | 26 ++
 rtl/fpu_seq_muldiv.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fpu_seq_muldiv_if.sv
// Handshake and operand bus for the sequential mantissa multiply/divide engine.
// The requester drives start/op/a/b/ack; the engine answers with status and results.
interface fpu_seq_muldiv_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, ack,
        input  busy, done, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, ack,
        output busy, done, result_hi, result_lo, div_by_zero
    );
endinterface

// File: rtl/fpu_seq_muldiv.sv
// Sequential unsigned mantissa engine: shift-add multiply or restoring divide
// on WIDTH-bit operands, one partial step per cycle, with a done/ack handshake
// and divide-by-zero detection.
module fpu_seq_muldiv #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             arst,
    fpu_seq_muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] LOAD         = 3'd1;
    localparam logic [2:0] MUL_ADD      = 3'd2;
    localparam logic [2:0] MUL_SHIFT    = 3'd3;
    localparam logic [2:0] DIV_SHIFT    = 3'd4;
    localparam logic [2:0] DIV_SUB_TEST = 3'd5;
    localparam logic [2:0] VALID        = 3'd6;

    logic [2:0]       state;
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    // acc_hi doubles as the remainder, acc_lo as the quotient during divide.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             dbz;

    logic [2*WIDTH:0] mul_shift;
    logic [WIDTH:0]   mul_sum;
    logic             rem_ge;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [CNT_W-1:0] cnt_dec;

    // Next-step datapath values shared by the iteration states.
    always_comb begin
        mul_shift = {acc_hi, acc_lo} >> 1;
        // acc_hi is below 2^WIDTH here (its carry was shifted out), so no overflow.
        mul_sum   = acc_hi + {1'b0, a_r};
        rem_ge    = (acc_hi >= {1'b0, b_r});
        rem_next  = rem_ge ? (acc_hi - {1'b0, b_r}) : acc_hi;
        quot_next = {acc_lo[WIDTH-1:1], rem_ge};
        cnt_dec   = cnt - CNT_W'(1);
    end

    // Control sequencer and datapath registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            op_r   <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r  <= bus.op;
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!op_r) begin
                        acc_hi <= '0;
                        acc_lo <= b_r;
                        cnt    <= CNT_W'(WIDTH);
                        state  <= MUL_ADD;
                    end else if (b_r == '0) begin
                        res_lo <= '1;
                        res_hi <= a_r;
                        dbz    <= 1'b1;
                        state  <= VALID;
                    end else begin
                        acc_hi <= '0;
                        acc_lo <= a_r;
                        cnt    <= CNT_W'(WIDTH);
                        state  <= DIV_SHIFT;
                    end
                end
                MUL_ADD: begin
                    if (acc_lo[0]) acc_hi <= mul_sum;
                    state <= MUL_SHIFT;
                end
                MUL_SHIFT: begin
                    {acc_hi, acc_lo} <= mul_shift;
                    cnt              <= cnt_dec;
                    if (cnt_dec == '0) begin
                        res_hi <= mul_shift[2*WIDTH-1:WIDTH];
                        res_lo <= mul_shift[WIDTH-1:0];
                        dbz    <= 1'b0;
                        state  <= VALID;
                    end else begin
                        state <= MUL_ADD;
                    end
                end
                DIV_SHIFT: begin
                    {acc_hi, acc_lo} <= {acc_hi[WIDTH-1:0], acc_lo, 1'b0};
                    state            <= DIV_SUB_TEST;
                end
                DIV_SUB_TEST: begin
                    acc_hi <= rem_next;
                    acc_lo <= quot_next;
                    cnt    <= cnt_dec;
                    if (cnt_dec == '0) begin
                        res_hi <= rem_next[WIDTH-1:0];
                        res_lo <= quot_next;
                        dbz    <= 1'b0;
                        state  <= VALID;
                    end else begin
                        state <= DIV_SHIFT;
                    end
                end
                VALID: begin
                    // start in the same cycle as ack is deliberately not looked at.
                    if (bus.ack) begin
                        dbz   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == VALID);
    assign bus.result_hi   = res_hi;
    assign bus.result_lo   = res_lo;
    assign bus.div_by_zero = dbz;
endmodule
